// File: rtl/cond_unit_mc.sv
// Multi-context conditional-execution unit: per-context NZCV flags, condition
// evaluation, gated controls, one-deep output register and saturating counters.
module cond_unit_mc #(
  parameter int NUM_CTX = 2,
  parameter int CNT_W   = 16,
  localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [CTX_W-1:0]         ctx_i,
  input  logic [3:0]               cond_i,
  input  logic [1:0]               flag_write_i,
  input  logic [3:0]               alu_flags_i,
  input  logic                     pcs_i,
  input  logic                     reg_w_i,
  input  logic                     mem_w_i,
  input  logic                     no_write_i,
  input  logic                     ld_i,
  input  logic [CTX_W-1:0]         ld_ctx_i,
  input  logic [3:0]               ld_flags_i,
  input  logic [CTX_W-1:0]         rd_ctx_i,
  output logic [3:0]               rd_flags_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [CTX_W-1:0]         ctx_o,
  output logic                     cond_ex_o,
  output logic                     pcs_o,
  output logic                     reg_w_o,
  output logic                     mem_w_o,
  output logic                     nv_o,
  output logic [NUM_CTX*CNT_W-1:0] exec_cnt_o,
  output logic [NUM_CTX*CNT_W-1:0] skip_cnt_o
);

  // One extra bit so NUM_CTX itself is representable for range checks.
  localparam logic [CTX_W:0] NCTX = (CTX_W+1)'(NUM_CTX);

  logic [3:0]       flags    [NUM_CTX];
  logic [CNT_W-1:0] exec_cnt [NUM_CTX];
  logic [CNT_W-1:0] skip_cnt [NUM_CTX];

  logic       ctx_ok, ld_ok, rd_ok;
  logic       accept, pass, is_nv;
  logic [3:0] cur_flags;

  function automatic logic cond_pass(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cf, v;
    logic r;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cf;
      4'b0011: r = ~cf;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cf & ~z;
      4'b1001: r = ~cf | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign ctx_ok  = {1'b0, ctx_i}    < NCTX;
  assign ld_ok   = {1'b0, ld_ctx_i} < NCTX;
  assign rd_ok   = {1'b0, rd_ctx_i} < NCTX;
  assign ready_o = ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;

  always_comb begin
    cur_flags = 4'b0000;
    if (ctx_ok) cur_flags = flags[ctx_i];
  end

  always_comb begin
    rd_flags_o = 4'b0000;
    if (rd_ok) rd_flags_o = flags[rd_ctx_i];
  end

  // Out-of-range contexts never pass and never report NV.
  assign pass  = ctx_ok & cond_pass(cur_flags, cond_i);
  assign is_nv = ctx_ok & (cond_i == 4'b1111);

  // Direct load overrides any ALU update to the same context on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CTX; k++) flags[k] <= 4'b0000;
    end else begin
      for (int k = 0; k < NUM_CTX; k++) begin
        if (ld_i && ld_ok && ld_ctx_i == CTX_W'(k)) begin
          flags[k] <= ld_flags_i;
        end else if (accept && pass && ctx_i == CTX_W'(k)) begin
          if (flag_write_i[1]) flags[k][3:2] <= alu_flags_i[3:2];
          if (flag_write_i[0]) flags[k][1:0] <= alu_flags_i[1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CTX; k++) begin
        exec_cnt[k] <= '0;
        skip_cnt[k] <= '0;
      end
    end else if (accept && ctx_ok) begin
      for (int k = 0; k < NUM_CTX; k++) begin
        if (ctx_i == CTX_W'(k)) begin
          if (pass) begin
            if (exec_cnt[k] != '1) exec_cnt[k] <= exec_cnt[k] + CNT_W'(1);
          end else begin
            if (skip_cnt[k] != '1) skip_cnt[k] <= skip_cnt[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o   <= 1'b0;
      ctx_o     <= '0;
      cond_ex_o <= 1'b0;
      pcs_o     <= 1'b0;
      reg_w_o   <= 1'b0;
      mem_w_o   <= 1'b0;
      nv_o      <= 1'b0;
    end else if (accept) begin
      valid_o   <= 1'b1;
      ctx_o     <= ctx_i;
      cond_ex_o <= pass;
      pcs_o     <= pcs_i & pass;
      reg_w_o   <= reg_w_i & pass & ~no_write_i;
      mem_w_o   <= mem_w_i & pass;
      nv_o      <= is_nv;
    end else if (ready_i) begin
      valid_o   <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CTX; g++) begin : g_pack
    assign exec_cnt_o[g*CNT_W +: CNT_W] = exec_cnt[g];
    assign skip_cnt_o[g*CNT_W +: CNT_W] = skip_cnt[g];
  end

endmodule

// File: tb/tb_cond_unit_mc.sv
// Bench for cond_unit_mc: directed scenarios then random traffic, all checked
// against a queue-based reference model through a separate monitor.
module tb_cond_unit_mc;
  localparam int NUM_CTX = 3;
  localparam int CNT_W   = 3;
  localparam int CTX_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, valid_i, ready_o, ready_i;
  logic [CTX_W-1:0] ctx_i, ld_ctx_i, rd_ctx_i, ctx_o;
  logic [3:0] cond_i, alu_flags_i, ld_flags_i, rd_flags_o;
  logic [1:0] flag_write_i;
  logic pcs_i, reg_w_i, mem_w_i, no_write_i, ld_i;
  logic valid_o, cond_ex_o, pcs_o, reg_w_o, mem_w_o, nv_o;
  logic [NUM_CTX*CNT_W-1:0] exec_cnt_o, skip_cnt_o;

  always #5 clk = ~clk;

  cond_unit_mc #(.NUM_CTX(NUM_CTX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .ctx_i(ctx_i), .cond_i(cond_i), .flag_write_i(flag_write_i),
    .alu_flags_i(alu_flags_i), .pcs_i(pcs_i), .reg_w_i(reg_w_i),
    .mem_w_i(mem_w_i), .no_write_i(no_write_i), .ld_i(ld_i),
    .ld_ctx_i(ld_ctx_i), .ld_flags_i(ld_flags_i), .rd_ctx_i(rd_ctx_i),
    .rd_flags_o(rd_flags_o), .valid_o(valid_o), .ready_i(ready_i),
    .ctx_o(ctx_o), .cond_ex_o(cond_ex_o), .pcs_o(pcs_o), .reg_w_o(reg_w_o),
    .mem_w_o(mem_w_o), .nv_o(nv_o), .exec_cnt_o(exec_cnt_o),
    .skip_cnt_o(skip_cnt_o)
  );

  typedef struct packed {
    logic [CTX_W-1:0] ctx;
    logic cex, pcs, rw, mw, nv;
  } item_t;

  item_t      q[$];
  logic [3:0] m_flags [4];
  int         m_exec [4];
  int         m_skip [4];
  bit         m_valid;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Conditions come in complementary pairs; bit 0 inverts the base test.
  function automatic bit m_pass(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cf, v, b;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return c[0] == 1'b0;
    endcase
    return c[0] ? !b : b;
  endfunction

  // Applies the effect of the coming clock edge to the model.
  task automatic edge_model();
    item_t it;
    bit acc, ok, p;
    logic [3:0] nf;
    #2;
    if (!rst_n) begin
      m_valid = 1'b0;
      q.delete();
      for (int k = 0; k < 4; k++) begin
        m_flags[k] = 4'b0; m_exec[k] = 0; m_skip[k] = 0;
      end
      return;
    end
    acc = valid_i && (!m_valid || ready_i);
    ok  = int'(ctx_i) < NUM_CTX;
    p   = ok && m_pass(m_flags[ctx_i], cond_i);
    if (acc) begin
      if (p) begin
        nf = m_flags[ctx_i];
        if (flag_write_i[1]) nf[3:2] = alu_flags_i[3:2];
        if (flag_write_i[0]) nf[1:0] = alu_flags_i[1:0];
        m_flags[ctx_i] = nf;
      end
      if (ok) begin
        if (p) m_exec[ctx_i] = (m_exec[ctx_i] < CMAX) ? m_exec[ctx_i] + 1 : CMAX;
        else   m_skip[ctx_i] = (m_skip[ctx_i] < CMAX) ? m_skip[ctx_i] + 1 : CMAX;
      end
      it.ctx = ctx_i;
      it.cex = p;
      it.pcs = pcs_i && p;
      it.rw  = reg_w_i && p && !no_write_i;
      it.mw  = mem_w_i && p;
      it.nv  = ok && (cond_i == 4'b1111);
      q.push_back(it);
      m_valid = 1'b1;
    end else if (ready_i) begin
      m_valid = 1'b0;
    end
    if (ld_i && int'(ld_ctx_i) < NUM_CTX) m_flags[ld_ctx_i] = ld_flags_i;
  endtask

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      chk("ready_o", 32'(ready_o), 32'(!m_valid || ready_i));
      chk("valid_o", 32'(valid_o), 32'(m_valid));
      chk("rd_flags_o", 32'(rd_flags_o),
          32'((int'(rd_ctx_i) < NUM_CTX) ? m_flags[rd_ctx_i] : 4'b0));
      for (int k = 0; k < NUM_CTX; k++) begin
        chk($sformatf("exec_cnt%0d", k), 32'(exec_cnt_o[k*CNT_W +: CNT_W]), 32'(m_exec[k]));
        chk($sformatf("skip_cnt%0d", k), 32'(skip_cnt_o[k*CNT_W +: CNT_W]), 32'(m_skip[k]));
      end
      if (valid_o) begin
        if (q.size() == 0) begin
          chk("result_unexpected", 32'(valid_o), 32'(0));
        end else begin
          chk("result", 32'({ctx_o, cond_ex_o, pcs_o, reg_w_o, mem_w_o, nv_o}), 32'(q[0]));
          if (ready_i) void'(q.pop_front());
        end
      end
    end
  end

  task automatic idle_inputs();
    valid_i = 0; ready_i = 1; ld_i = 0; ctx_i = 0; cond_i = 0; flag_write_i = 0;
    alu_flags_i = 0; pcs_i = 0; reg_w_i = 0; mem_w_i = 0; no_write_i = 0;
    ld_ctx_i = 0; ld_flags_i = 0; rd_ctx_i = 0;
  endtask

  task automatic op(input logic [1:0] c, input logic [3:0] cnd, input logic [1:0] fw,
                    input logic [3:0] alu, input bit rdy);
    @(negedge clk);
    idle_inputs();
    valid_i = 1; ready_i = rdy; ctx_i = c; cond_i = cnd; flag_write_i = fw;
    alu_flags_i = alu; pcs_i = 1; reg_w_i = 1; mem_w_i = 1; rd_ctx_i = c;
    edge_model();
  endtask

  task automatic load(input logic [1:0] c, input logic [3:0] f);
    @(negedge clk);
    idle_inputs();
    ld_i = 1; ld_ctx_i = c; ld_flags_i = f; rd_ctx_i = c;
    edge_model();
  endtask

  task automatic idle_cycle(input logic [1:0] rc);
    @(negedge clk);
    idle_inputs();
    rd_ctx_i = rc;
    edge_model();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    edge_model();
    mon_en = 1'b1;
    @(negedge clk);
    rst_n = 1;
    edge_model();

    op(0, 4'b0000, 2'b00, 4'h0, 1);
    op(0, 4'b0001, 2'b00, 4'h0, 1);
    op(0, 4'b1110, 2'b11, 4'b0100, 1);
    op(0, 4'b0000, 2'b00, 4'h0, 1);
    op(0, 4'b0000, 2'b10, 4'b1000, 1);
    idle_cycle(0);

    load(1, 4'b1001);
    load(0, 4'b0000);
    op(1, 4'b1010, 2'b00, 4'h0, 1);
    op(0, 4'b1010, 2'b00, 4'h0, 1);
    op(1, 4'b1011, 2'b11, 4'b1111, 1);
    idle_cycle(1);

    op(2, 4'b1110, 2'b11, 4'b0101, 0);
    for (int i = 0; i < 3; i++) op(2, 4'b0000, 2'b11, 4'b1010, 0);
    for (int i = 0; i < 3; i++) op(2, 4'b0001, 2'b00, 4'h0, 1);
    idle_cycle(2);

    for (int i = 0; i < 9; i++) op(2, 4'b1111, 2'b11, 4'hf, 1);
    op(3, 4'b1110, 2'b11, 4'hf, 1);
    load(3, 4'hf);
    idle_cycle(3);

    @(negedge clk);
    idle_inputs();
    valid_i = 1; ctx_i = 0; cond_i = 4'b1110; flag_write_i = 2'b11;
    alu_flags_i = 4'b1001; ld_i = 1; ld_ctx_i = 0; ld_flags_i = 4'b0110;
    edge_model();
    idle_cycle(0);

    op(1, 4'b1110, 2'b00, 4'h0, 0);
    op(1, 4'b1110, 2'b00, 4'h0, 0);
    @(negedge clk);
    idle_inputs();
    ready_i = 0; rst_n = 0;
    edge_model();
    @(negedge clk);
    rst_n = 1;
    edge_model();
    idle_cycle(0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n        = ($urandom_range(0, 399) != 0);
      valid_i      = ($urandom_range(0, 3) != 0);
      ready_i      = ($urandom_range(0, 9) < 7);
      ctx_i        = CTX_W'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2));
      cond_i       = 4'($urandom);
      flag_write_i = 2'($urandom);
      alu_flags_i  = 4'($urandom);
      pcs_i        = 1'($urandom);
      reg_w_i      = 1'($urandom);
      mem_w_i      = 1'($urandom);
      no_write_i   = 1'($urandom);
      ld_i         = ($urandom_range(0, 9) == 0);
      ld_ctx_i     = 2'($urandom);
      ld_flags_i   = 4'($urandom);
      rd_ctx_i     = 2'($urandom);
      edge_model();
    end
    rst_n = 1;
    for (int i = 0; i < 4; i++) idle_cycle(2'(i));
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
